lsq_ret_seq: RTL and testbench
==============================

# lsq_ret_seq

Retire-group sequencer for the load/store queue. It sits between the two per-thread LSQ retire heads and the retire-decision stage that feeds the control unit. Each cycle it picks at most one thread's completed group and presents its 6-bit group ID (II) to the control unit. It completes the pop handshake when the control unit retires that II, and tracks the expected in-order II per thread. Exception flushes and hung offers are handled here.

## Interface
Parameters:
- FLUSH_CYC, 2, cycles a thread stays blocked after an exception (1..15)
- TIMEOUT, 255, offer-age threshold for `stuck` (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- grp_ready  in  2  thread t has a completed group at its LSQ retire head
- grp_II0  in  6  head-group II, thread 0
- grp_II1  in  6  head-group II, thread 1
- doRetire  in  1  control unit retires `cntrl_II` this cycle
- cntrl_II  in  6  II being retired by the control unit
- bStall  in  1  backend stall; blocks acceptance
- except  in  1  exception/flush request
- except_thread  in  1  thread being flushed
- except_II  in  6  II at which the flushed thread resumes
- out_valid  out  1  an offer is being presented
- out_thread  out  1  thread of the offered group
- out_II  out  6  II of the offered group
- lsq_pop  out  2  one-hot pop of the thread's retire head (combinational)
- seq_err  out  1  sticky flag: head II did not equal expected II
- stuck  out  1  offer age reached TIMEOUT

## Operation
- State per thread: exp_II[t] (6 bits, wraps 63->0); blk_cnt[t] (4 bits).
- Global FSM states:
  - IDLE: no offer.
  - OFFER: out_valid=1; out_thread and out_II are held stable.
  - Reset puts the FSM in IDLE.
- Eligibility of thread t: grp_ready[t], grp_IIt==exp_II[t], blk_cnt[t]==0, and no except for t in the same cycle.
- Mismatch case: grp_ready[t] with II≠exp_II[t] and blk_cnt[t]==0 sets seq_err, which is cleared only by rst. That thread is not offered.
- IDLE -> OFFER when a thread is eligible:
  - Only one eligible: that thread is picked.
  - Both eligible: round-robin, using a 1-bit `last` pointer (reset 1, so thread 0 wins first).
  - Offer fields are registered: out_thread=picked thread, out_II=exp_II[picked].
- accept = out_valid & doRetire & (cntrl_II==out_II) & ~bStall & ~(except & except_thread==out_thread).
- On accept:
  - lsq_pop[out_thread]=1 in the same cycle.
  - Next cycle: exp_II[out_thread] increments, `last` is set to out_thread, FSM goes to IDLE.
- OFFER with doRetire and a mismatching cntrl_II: no pop; the offer stays held.
- Exception for thread t:
  - Next cycle: exp_II[t]=except_II and blk_cnt[t]=FLUSH_CYC.
  - If OFFER is for t, the FSM goes to IDLE with no pop.
  - blk_cnt[t] decrements to 0.
  - The other thread's offer is unaffected.
- Age counter:
  - 8 bits, clears on entering OFFER and increments each OFFER cycle, saturating.
  - stuck = (age ≥ TIMEOUT) while in OFFER.
  - stuck is informational only; it does not drop the offer.
- Reset values: out_valid 0, out_thread 0, out_II 0, lsq_pop 0, seq_err 0, stuck 0, exp_II 0/0, blk_cnt 0/0, age 0.
- Reset mid-offer drops the offer with no pop.

## Timing
- Sampling: grp_ready/grp_II sampled in cycle N -> out_valid in N+1.
- Pop: accept in cycle M -> lsq_pop pulse in M. The LSQ must update its head by M+1.
- Back-to-back offers: earliest next offer is M+2 (IDLE at M+1). Peak rate is one group per 2 cycles.
- bStall:
  - Holds OFFER indefinitely; the pop waits.
  - Does not affect exception handling.
- Exception and accept in the same cycle, same thread: the exception wins; no pop.
- Exception and accept in the same cycle, other thread: the pop proceeds.
- Exception blocking: an exception at E keeps thread t ineligible through E+FLUSH_CYC. The earliest offer for t is at E+FLUSH_CYC+2.

## Test plan
- Single-thread stream:
  - Stimulus: after reset, grp_ready=01 with grp_II0=0,1,2; doRetire echoes out_II.
  - Required: offers II 0,1,2 every 2 cycles; lsq_pop=01 three times; exp_II0 ends at 3.
- Round-robin:
  - Stimulus: both threads ready (II 0) continuously; doRetire echoes out_II.
  - Required: out_thread sequence 0,1,0,1; no pop lost.
- Stall:
  - Stimulus: OFFER II 5, bStall=1 for 10 cycles with doRetire=1.
  - Required: no pop and out_II stays 5 throughout; pop is in the first cycle after bStall drops.
- Flush:
  - Stimulus: offer thread 1 II 9; in the same cycle, except=1, except_thread=1, except_II=4, doRetire=1, cntrl_II=9.
  - Required: no pop; out_valid 0 next cycle; next thread-1 offer is II 4, no earlier than E+4.
- Error/timeout:
  - Stimulus: grp_II0=7 while exp_II0=0.
  - Required: seq_err=1, no offer.
  - Stimulus: separately, hold an offer without doRetire for 255 cycles.
  - Required: stuck=1 at age 255.
- Wrap-around:
  - Stimulus: drive 64 consecutive retirements on thread 0.
  - Required: II wraps 63->0 with seq_err staying 0.

Source files
------------

// File: rtl/lsq_ret_seq.sv
// Retire-group sequencer: offers one thread's in-order LSQ retire group per
// cycle to the control unit, pops the LSQ head on retirement, handles flushes.
module lsq_ret_seq #(
  parameter int FLUSH_CYC = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] grp_ready,
  input  logic [5:0] grp_II0,
  input  logic [5:0] grp_II1,
  input  logic       doRetire,
  input  logic [5:0] cntrl_II,
  input  logic       bStall,
  input  logic       except,
  input  logic       except_thread,
  input  logic [5:0] except_II,
  output logic       out_valid,
  output logic       out_thread,
  output logic [5:0] out_II,
  output logic [1:0] lsq_pop,
  output logic       seq_err,
  output logic       stuck
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state, state_nxt;
  logic [5:0] exp_ii  [2];
  logic [3:0] blk_cnt [2];
  logic [5:0] grp_ii  [2];
  logic       last;
  logic [7:0] age;
  logic [1:0] elig, mism;
  logic       pick, flush_cur, accept;

  assign grp_ii[0] = grp_II0;
  assign grp_ii[1] = grp_II1;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    elig = '0;
    mism = '0;
    for (int t = 0; t < 2; t++) begin
      if (grp_ready[t] && blk_cnt[t] == 4'd0) begin
        if (grp_ii[t] == exp_ii[t])
          elig[t] = !(except && except_thread == 1'(t));
        else
          mism[t] = 1'b1;
      end
    end
  end

  // Round-robin only matters when both threads are eligible.
  assign pick      = (elig == 2'b11) ? ~last : elig[1];
  assign flush_cur = except && (except_thread == out_thread);
  // Gated by rst so a reset arriving mid-offer never pops the LSQ.
  assign accept    = out_valid && doRetire && (cntrl_II == out_II) &&
                     !bStall && !flush_cur && !rst;

  assign out_valid = (state == OFFER);
  assign lsq_pop   = accept ? (out_thread ? 2'b10 : 2'b01) : 2'b00;
  assign stuck     = (state == OFFER) && (age >= 8'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (elig != 2'b00) state_nxt = OFFER;
      OFFER:   if (accept || flush_cur) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_thread <= 1'b0;
      out_II     <= '0;
      seq_err    <= 1'b0;
      last       <= 1'b1;
      age        <= '0;
      for (int t = 0; t < 2; t++) begin
        exp_ii[t]  <= '0;
        blk_cnt[t] <= '0;
      end
    end else begin
      state   <= state_nxt;
      seq_err <= seq_err | (|mism);

      if (state == IDLE && elig != 2'b00) begin
        out_thread <= pick;
        out_II     <= exp_ii[pick];
        age        <= '0;
      end else if (state == OFFER && age != 8'hFF) begin
        age <= age + 8'd1;
      end

      if (accept) last <= out_thread;

      for (int t = 0; t < 2; t++) begin
        if (except && except_thread == 1'(t)) begin
          exp_ii[t]  <= except_II;
          blk_cnt[t] <= 4'(FLUSH_CYC);
        end else begin
          if (accept && out_thread == 1'(t)) exp_ii[t] <= exp_ii[t] + 6'd1;
          if (blk_cnt[t] != 4'd0) blk_cnt[t] <= blk_cnt[t] - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsq_ret_seq.sv
// Self-checking bench for lsq_ret_seq: a directed vector table for flush and
// handshake behaviour, plus hand sequences for streaming, stalls and timeouts.
module tb_lsq_ret_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grp_ready;
  logic [5:0] grp_II0, grp_II1;
  logic       doRetire;
  logic [5:0] cntrl_II;
  logic       bStall;
  logic       except, except_thread;
  logic [5:0] except_II;
  logic       out_valid, out_thread;
  logic [5:0] out_II;
  logic [1:0] lsq_pop;
  logic       seq_err, stuck;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsq_ret_seq #(.FLUSH_CYC(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .grp_ready(grp_ready), .grp_II0(grp_II0),
    .grp_II1(grp_II1), .doRetire(doRetire), .cntrl_II(cntrl_II),
    .bStall(bStall), .except(except), .except_thread(except_thread),
    .except_II(except_II), .out_valid(out_valid), .out_thread(out_thread),
    .out_II(out_II), .lsq_pop(lsq_pop), .seq_err(seq_err), .stuck(stuck)
  );

  typedef struct {
    logic [1:0] rdy;
    logic [5:0] ii0, ii1;
    logic       dr;
    logic [5:0] cii;
    logic       exc, exc_t;
    logic [5:0] exc_ii;
    logic       e_valid, e_thread;
    logic [5:0] e_ii;
    logic [1:0] e_pop;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  // Echo-loop bookkeeping: modelled LSQ heads and a log of observed pops.
  logic [5:0] head [2];
  int         cnt  [2];
  int         pop_thr[$], pop_ii[$], pop_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    grp_ready = 2'b00; grp_II0 = '0; grp_II1 = '0;
    doRetire = 1'b0; cntrl_II = '0; bStall = 1'b0;
    except = 1'b0; except_thread = 1'b0; except_II = '0;
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) next_cyc();
    rst = 1'b0;
  endtask

  task automatic add(input logic [1:0] rdy, input logic [5:0] ii0, input logic [5:0] ii1,
                     input logic dr, input logic [5:0] cii,
                     input logic exc, input logic exc_t, input logic [5:0] exc_ii,
                     input logic ev, input logic et, input logic [5:0] eii,
                     input logic [1:0] epop, input logic eerr);
    vec_t v;
    v.rdy = rdy; v.ii0 = ii0; v.ii1 = ii1; v.dr = dr; v.cii = cii;
    v.exc = exc; v.exc_t = exc_t; v.exc_ii = exc_ii;
    v.e_valid = ev; v.e_thread = et; v.e_ii = eii; v.e_pop = epop; v.e_err = eerr;
    tbl.push_back(v);
  endtask

  // Control unit echoes the offer; the LSQ head advances after each pop.
  task automatic echo_run(input int ncyc, input int lim0, input int lim1);
    int lim [2];
    lim[0] = lim0; lim[1] = lim1;
    for (int c = 0; c < ncyc; c++) begin
      grp_ready[0] = (cnt[0] < lim[0]);
      grp_ready[1] = (cnt[1] < lim[1]);
      grp_II0  = head[0];
      grp_II1  = head[1];
      doRetire = out_valid;
      cntrl_II = out_II;
      #1;
      if (lsq_pop != 2'b00) begin
        int t;
        t = (lsq_pop == 2'b10) ? 1 : 0;
        pop_thr.push_back(t);
        pop_ii.push_back(int'(out_II));
        pop_cyc.push_back(c);
        head[t] = head[t] + 6'd1;
        cnt[t]++;
      end
      next_cyc();
    end
    idle_inputs();
  endtask

  task automatic clear_log();
    head[0] = '0; head[1] = '0; cnt[0] = 0; cnt[1] = 0;
    pop_thr.delete(); pop_ii.delete(); pop_cyc.delete();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) next_cyc();
    rst = 1'b0;
    #1;
    check("reset_valid",  out_valid,  0);
    check("reset_thread", out_thread, 0);
    check("reset_ii",     out_II,     0);
    check("reset_pop",    lsq_pop,    0);
    check("reset_err",    seq_err,    0);
    check("reset_stuck",  stuck,      0);

    // ---- Vector table: flush on thread 1, cross-thread flush, CU mismatch, seq_err
    add(2'b00, 0, 0, 0, 0,  1, 1, 9,   0, 0, 0, 2'b00, 0);
    add(2'b10, 0, 9, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b10, 0, 9, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b10, 0, 9, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b10, 0, 9, 1, 9,  1, 1, 4,   1, 1, 9, 2'b00, 0);
    add(2'b10, 0, 4, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b10, 0, 4, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b10, 0, 4, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b10, 0, 4, 1, 4,  0, 0, 0,   1, 1, 4, 2'b10, 0);
    add(2'b01, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b01, 0, 0, 1, 0,  1, 1, 20,  1, 0, 0, 2'b01, 0);
    add(2'b00, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b01, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b01, 1, 0, 1, 5,  0, 0, 0,   1, 0, 1, 2'b00, 0);
    add(2'b01, 1, 0, 1, 1,  0, 0, 0,   1, 0, 1, 2'b01, 0);
    add(2'b00, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b01, 7, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 0);
    add(2'b00, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2'b00, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      grp_ready = tbl[i].rdy; grp_II0 = tbl[i].ii0; grp_II1 = tbl[i].ii1;
      doRetire = tbl[i].dr; cntrl_II = tbl[i].cii;
      except = tbl[i].exc; except_thread = tbl[i].exc_t; except_II = tbl[i].exc_ii;
      #1;
      check($sformatf("vec%0d_valid", i), out_valid, tbl[i].e_valid);
      check($sformatf("vec%0d_pop", i),   lsq_pop,   tbl[i].e_pop);
      check($sformatf("vec%0d_err", i),   seq_err,   tbl[i].e_err);
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d_thread", i), out_thread, tbl[i].e_thread);
        check($sformatf("vec%0d_ii", i),     out_II,     tbl[i].e_ii);
      end
      next_cyc();
    end
    idle_inputs();

    // ---- Single-thread stream: II 0,1,2 every 2 cycles, then II 3 expected
    do_reset();
    clear_log();
    echo_run(8, 3, 0);
    check("stream_pops", pop_thr.size(), 3);
    if (pop_thr.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("stream_thr%0d", k), pop_thr[k], 0);
        check($sformatf("stream_ii%0d", k),  pop_ii[k],  k);
      end
      check("stream_gap01", pop_cyc[1] - pop_cyc[0], 2);
      check("stream_gap12", pop_cyc[2] - pop_cyc[1], 2);
    end
    echo_run(4, 4, 0);
    check("stream_exp3_pops", pop_thr.size(), 4);
    if (pop_thr.size() == 4) check("stream_exp3_ii", pop_ii[3], 3);
    check("stream_err", seq_err, 0);

    // ---- Round-robin between both threads
    do_reset();
    clear_log();
    echo_run(12, 2, 2);
    check("rr_pops", pop_thr.size(), 4);
    if (pop_thr.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_thr%0d", k), pop_thr[k], k % 2);
        check($sformatf("rr_ii%0d", k),  pop_ii[k],  k / 2);
      end
    end

    // ---- Wrap-around: 65 retirements on thread 0 cross 63 -> 0
    do_reset();
    clear_log();
    echo_run(140, 65, 0);
    check("wrap_pops", pop_thr.size(), 65);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < pop_ii.size(); k++)
        if (pop_ii[k] != (k % 64) || pop_thr[k] != 0) bad++;
      check("wrap_seq_bad", bad, 0);
    end
    if (pop_ii.size() == 65) check("wrap_last_ii", pop_ii[64], 0);
    check("wrap_err", seq_err, 0);

    // ---- Stall: offer II 5 held for 10 stalled cycles, pops once stall drops
    do_reset();
    except = 1'b1; except_thread = 1'b0; except_II = 6'd5;
    next_cyc();
    except = 1'b0;
    grp_ready = 2'b01; grp_II0 = 6'd5;
    repeat (2) begin
      #1;
      check("stall_blocked_valid", out_valid, 0);
      next_cyc();
    end
    next_cyc();
    bStall = 1'b1; doRetire = 1'b1; cntrl_II = 6'd5;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("stall%0d_valid", k), out_valid, 1);
      check($sformatf("stall%0d_ii", k),    out_II,    5);
      check($sformatf("stall%0d_pop", k),   lsq_pop,   0);
      next_cyc();
    end
    bStall = 1'b0;
    #1;
    check("stall_release_pop", lsq_pop, 2'b01);
    next_cyc();
    grp_ready = 2'b00; doRetire = 1'b0;
    #1;
    check("stall_after_valid", out_valid, 0);
    idle_inputs();

    // ---- Timeout: stuck at age 255, offer not dropped
    do_reset();
    grp_ready = 2'b01; grp_II0 = 6'd0;
    next_cyc();
    for (int k = 0; k <= 300; k++) begin
      #1;
      if (k == 0 || k == 254) check($sformatf("age%0d_stuck", k), stuck, 0);
      if (k == 255 || k == 300) begin
        check($sformatf("age%0d_stuck", k), stuck, 1);
        check($sformatf("age%0d_valid", k), out_valid, 1);
      end
      next_cyc();
    end

    // ---- Reset mid-offer: no pop, offer dropped
    doRetire = 1'b1; cntrl_II = 6'd0; rst = 1'b1;
    #1;
    check("rst_mid_pop", lsq_pop, 0);
    next_cyc();
    rst = 1'b0; doRetire = 1'b0; grp_ready = 2'b00;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_stuck", stuck, 0);

    // ---- Sequence error after reset: head II 7 while expecting 0
    grp_ready = 2'b01; grp_II0 = 6'd7;
    next_cyc();
    #1;
    check("seqerr_set", seq_err, 1);
    check("seqerr_no_offer", out_valid, 0);
    next_cyc();
    grp_ready = 2'b00;
    #1;
    check("seqerr_sticky", seq_err, 1);
    check("seqerr_no_offer2", out_valid, 0);
    do_reset();
    #1;
    check("seqerr_cleared", seq_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
